// File: rtl/vcve2_dmem_rr_arbiter.sv
// Round-robin / fixed-priority arbiter from N core-side masters onto one OBI data port.
// In-flight port IDs are queued so each response is routed back to its originating master.
module vcve2_dmem_rr_arbiter #(
    parameter int unsigned  NUM_PORTS       = 2,
    parameter int unsigned  DATA_WIDTH      = 32,
    parameter int unsigned  ADDR_WIDTH      = 32,
    parameter int unsigned  MAX_OUTSTANDING = 2,
    parameter bit           FIXED_PRIO      = 1'b0,
    localparam int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    localparam int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_PORTS-1:0]            req_i,
    input  logic [NUM_PORTS-1:0]            lock_i,
    input  logic [NUM_PORTS-1:0]            we_i,
    input  logic [NUM_PORTS*BE_WIDTH-1:0]   be_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]            gnt_o,
    output logic [NUM_PORTS-1:0]            rvalid_o,
    output logic [NUM_PORTS-1:0]            err_o,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic                            data_req_o,
    input  logic                            data_gnt_i,
    output logic                            data_we_o,
    output logic [BE_WIDTH-1:0]             data_be_o,
    output logic [ADDR_WIDTH-1:0]           data_addr_o,
    output logic [DATA_WIDTH-1:0]           data_wdata_o,
    input  logic                            data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]           data_rdata_i,
    input  logic                            data_err_i,
    output logic [CNT_WIDTH-1:0]            outstanding_o
);

    localparam int unsigned IDX_WIDTH = $clog2(NUM_PORTS);
    localparam int unsigned PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef logic [IDX_WIDTH-1:0] idx_t;
    typedef logic [PTR_WIDTH-1:0] ptr_t;

    function automatic idx_t lowest_set(input logic [NUM_PORTS-1:0] vec);
        idx_t idx;
        idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (vec[i]) idx = idx_t'(i);
        end
        return idx;
    endfunction

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [NUM_PORTS-1:0] mask_q, mask_d;
    logic                 pending_q, pending_d;
    idx_t                 pend_idx_q, pend_idx_d;
    idx_t                 fifo_q [MAX_OUTSTANDING];
    ptr_t                 wptr_q, rptr_q;
    logic [CNT_WIDTH-1:0] count_q;

    logic [NUM_PORTS-1:0] locked, masked;
    idx_t                 arb_idx, win_idx, head_idx;
    logic                 full, push, pop;

    // Lock overrides everything; otherwise fixed priority or the lowest port above the last grant.
    always_comb begin
        locked = req_i & lock_i;
        masked = req_i & mask_q;
        if (|locked) begin
            arb_idx = lowest_set(locked);
        end else if (FIXED_PRIO || !(|masked)) begin
            arb_idx = lowest_set(req_i);
        end else begin
            arb_idx = lowest_set(masked);
        end
    end

    // A stalled request keeps its winner so the OBI address phase stays stable until granted.
    assign win_idx    = pending_q ? pend_idx_q : arb_idx;
    assign full       = (count_q == CNT_WIDTH'(MAX_OUTSTANDING));
    assign data_req_o = ~full & (pending_q | (|req_i));
    assign push       = data_req_o & data_gnt_i;
    assign pop        = data_rvalid_i & (count_q != '0);
    assign head_idx   = fifo_q[rptr_q];

    always_comb begin
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_addr_o  = '0;
        data_wdata_o = '0;
        gnt_o        = '0;
        if (data_req_o) begin
            data_we_o      = we_i[win_idx];
            data_be_o      = be_i[win_idx*BE_WIDTH +: BE_WIDTH];
            data_addr_o    = addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            data_wdata_o   = wdata_i[win_idx*DATA_WIDTH +: DATA_WIDTH];
            gnt_o[win_idx] = data_gnt_i;
        end
    end

    always_comb begin
        rvalid_o           = '0;
        err_o              = '0;
        rvalid_o[head_idx] = pop;
        err_o[head_idx]    = pop & data_err_i;
    end

    assign rdata_o       = data_rdata_i;
    assign outstanding_o = count_q;

    always_comb begin
        mask_d     = mask_q;
        pending_d  = pending_q;
        pend_idx_d = pend_idx_q;
        if (push) begin
            pending_d = 1'b0;
            if (!FIXED_PRIO) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    mask_d[i] = (i > int'(win_idx));
                end
            end
        end else if (data_req_o) begin
            pending_d  = 1'b1;
            pend_idx_d = win_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q     <= '1;
            pending_q  <= 1'b0;
            pend_idx_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            mask_q     <= mask_d;
            pending_q  <= pending_d;
            pend_idx_q <= pend_idx_d;
            if (push) begin
                fifo_q[wptr_q] <= win_idx;
                wptr_q         <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_vcve2_dmem_rr_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants/responses, a negedge monitor pops and compares.
// A second instance with FIXED_PRIO=1 covers fixed-priority arbitration.
module tb_vcve2_dmem_rr_arbiter;

    localparam int NP = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 2;
    localparam int BW = DW / 8;
    localparam int CW = $clog2(MO + 1);

    localparam logic [AW-1:0] ADDR0 = 32'h1000_0000;
    localparam logic [AW-1:0] ADDR1 = 32'h2000_0004;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic [NP-1:0] req_i, req_f, lock_i, we_i;
    logic [NP*BW-1:0] be_i;
    logic [NP*AW-1:0] addr_i;
    logic [NP*DW-1:0] wdata_i;
    logic data_gnt_i, data_rvalid_i, data_err_i;
    logic [DW-1:0] data_rdata_i;

    logic [NP-1:0] gnt_o, rvalid_o, err_o;
    logic [DW-1:0] rdata_o;
    logic data_req_o, data_we_o;
    logic [BW-1:0] data_be_o;
    logic [AW-1:0] data_addr_o;
    logic [DW-1:0] data_wdata_o;
    logic [CW-1:0] outstanding_o;

    logic [NP-1:0] f_gnt, f_rvalid, f_err;
    logic [DW-1:0] f_rdata;
    logic f_req, f_we;
    logic [BW-1:0] f_be;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_wdata;
    logic [CW-1:0] f_out;

    int checks = 0;
    int errors = 0;
    int exp_gnt[$];
    int fix_gnt[$];
    rsp_t exp_rsp[$];
    rsp_t fix_rsp[$];

    always #5 clk = ~clk;

    vcve2_dmem_rr_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO), .FIXED_PRIO(1'b0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .lock_i(lock_i), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o),
        .rdata_o(rdata_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_addr_o(data_addr_o),
        .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i),
        .data_rdata_i(data_rdata_i), .data_err_i(data_err_i), .outstanding_o(outstanding_o)
    );

    vcve2_dmem_rr_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO), .FIXED_PRIO(1'b1)
    ) u_fix (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_f), .lock_i(lock_i), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(f_gnt), .rvalid_o(f_rvalid), .err_o(f_err),
        .rdata_o(f_rdata), .data_req_o(f_req), .data_gnt_i(data_gnt_i), .data_we_o(f_we),
        .data_be_o(f_be), .data_addr_o(f_addr), .data_wdata_o(f_wdata),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
        .outstanding_o(f_out)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] lk, input logic g,
                         input logic rv, input logic e);
        req_i         = r;
        lock_i        = lk;
        data_gnt_i    = g;
        data_rvalid_i = rv;
        data_err_i    = e;
        data_rdata_i  = $urandom;
    endtask

    task automatic push_rsp(input int p, input logic e);
        rsp_t r;
        r.port  = p;
        r.err   = e;
        r.rdata = data_rdata_i;
        exp_rsp.push_back(r);
    endtask

    task automatic push_fix_rsp(input int p);
        rsp_t r;
        r.port  = p;
        r.err   = 1'b0;
        r.rdata = data_rdata_i;
        fix_rsp.push_back(r);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares whatever both arbiters present against the scoreboard queues.
    rsp_t        mr;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = '0;

    always @(negedge clk) begin
        if (gnt_o != '0) begin
            if (exp_gnt.size() == 0) chk("gnt_unexpected", 64'(gnt_o), 64'd0);
            else chk("gnt", 64'(gnt_o), 64'd1 << exp_gnt.pop_front());
        end
        if (rvalid_o != '0) begin
            if (exp_rsp.size() == 0) begin
                chk("rvalid_unexpected", 64'(rvalid_o), 64'd0);
            end else begin
                mr = exp_rsp.pop_front();
                chk("rvalid", 64'(rvalid_o), 64'd1 << mr.port);
                chk("err", 64'(err_o), mr.err ? (64'd1 << mr.port) : 64'd0);
                chk("rdata", 64'(rdata_o), 64'(mr.rdata));
            end
        end
        if (f_gnt != '0) begin
            if (fix_gnt.size() == 0) chk("fix_gnt_unexpected", 64'(f_gnt), 64'd0);
            else chk("fix_gnt", 64'(f_gnt), 64'd1 << fix_gnt.pop_front());
        end
        if (f_rvalid != '0) begin
            if (fix_rsp.size() == 0) begin
                chk("fix_rvalid_unexpected", 64'(f_rvalid), 64'd0);
            end else begin
                mr = fix_rsp.pop_front();
                chk("fix_rvalid", 64'(f_rvalid), 64'd1 << mr.port);
            end
        end
        if (rst_ni && prev_stall) chk("hold_addr", 64'(data_addr_o), 64'(prev_addr));
        prev_stall = rst_ni && data_req_o && !data_gnt_i;
        prev_addr  = data_addr_o;
    end

    int g5 [5] = '{1, 1, 1, 0, 1};

    initial begin
        req_i = '0;
        req_f = '0;
        lock_i = '0;
        we_i = 2'b10;
        be_i = {4'hC, 4'h3};
        addr_i = {ADDR1, ADDR0};
        wdata_i = {32'hBBBB_0001, 32'hAAAA_0000};
        data_gnt_i = 1'b0;
        data_rvalid_i = 1'b0;
        data_err_i = 1'b0;
        data_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;

        settle();
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("rst_req", 64'(data_req_o), 64'd0);
        chk("rst_addr", 64'(data_addr_o), 64'd0);
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        next();

        // Round-robin alternation with 1-cycle memory latency.
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 2'b00, 1'b1, i > 0, 1'b0);
            exp_gnt.push_back(i % 2);
            if (i > 0) push_rsp((i - 1) % 2, 1'b0);
            settle();
            chk("t1_addr", 64'(data_addr_o), (i % 2) ? 64'(ADDR1) : 64'(ADDR0));
            chk("t1_we", 64'(data_we_o), 64'(i % 2));
            chk("t1_be", 64'(data_be_o), (i % 2) ? 64'hC : 64'h3);
            next();
        end
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        push_rsp(1, 1'b0);
        settle();
        chk("t1_outstanding", 64'(outstanding_o), 64'd1);
        next();

        // Pending hold: port 1 stalls three cycles while port 0 joins.
        drive(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t2_addr_c1", 64'(data_addr_o), 64'(ADDR1));
        next();
        for (int i = 0; i < 2; i++) begin
            drive(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
            settle();
            chk("t2_addr_hold", 64'(data_addr_o), 64'(ADDR1));
            chk("t2_no_gnt", 64'(gnt_o), 64'd0);
            next();
        end
        drive(2'b11, 2'b00, 1'b1, 1'b0, 1'b0);
        exp_gnt.push_back(1);
        settle();
        chk("t2_addr_c4", 64'(data_addr_o), 64'(ADDR1));
        next();
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        push_rsp(1, 1'b0);
        settle();
        next();

        // Outstanding limit.
        for (int i = 0; i < 2; i++) begin
            drive(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
            exp_gnt.push_back(0);
            settle();
            next();
        end
        drive(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t3_full_req", 64'(data_req_o), 64'd0);
        chk("t3_full_cnt", 64'(outstanding_o), 64'd2);
        next();
        drive(2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
        push_rsp(0, 1'b0);
        settle();
        chk("t3_full_pop_req", 64'(data_req_o), 64'd0);
        next();
        drive(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        exp_gnt.push_back(0);
        settle();
        chk("t3_regrant_req", 64'(data_req_o), 64'd1);
        chk("t3_regrant_cnt", 64'(outstanding_o), 64'd1);
        next();
        for (int i = 0; i < 2; i++) begin
            drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
            push_rsp(0, 1'b0);
            settle();
            chk("t3_drain_cnt", 64'(outstanding_o), 64'(2 - i));
            next();
        end
        drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t3_empty_cnt", 64'(outstanding_o), 64'd0);
        next();

        // Fixed priority on the second instance; main arbiter sees only stale rvalids.
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 2'b00, 1'b1, i > 0, 1'b0);
            req_f = 2'b11;
            fix_gnt.push_back(0);
            if (i > 0) push_fix_rsp(0);
            settle();
            chk("t4_fix_addr", 64'(f_addr), 64'(ADDR0));
            next();
        end
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        req_f = 2'b00;
        push_fix_rsp(0);
        settle();
        chk("t4_main_cnt", 64'(outstanding_o), 64'd0);
        next();

        // Lock on port 1, then round-robin resumes at port 0.
        for (int i = 0; i < 5; i++) begin
            drive(2'b11, (i < 3) ? 2'b10 : 2'b00, 1'b1, i > 0, 1'b0);
            exp_gnt.push_back(g5[i]);
            if (i > 0) push_rsp(g5[i-1], 1'b0);
            settle();
            next();
        end
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        push_rsp(1, 1'b0);
        settle();
        next();

        // Error routing, then reset with two in flight.
        drive(2'b10, 2'b00, 1'b1, 1'b0, 1'b0);
        exp_gnt.push_back(1);
        settle();
        next();
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        push_rsp(1, 1'b1);
        settle();
        chk("t6_err", 64'(err_o), 64'b10);
        next();
        drive(2'b11, 2'b00, 1'b1, 1'b0, 1'b0);
        exp_gnt.push_back(0);
        settle();
        next();
        drive(2'b11, 2'b00, 1'b1, 1'b0, 1'b0);
        exp_gnt.push_back(1);
        settle();
        next();
        drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t6_pre_rst_cnt", 64'(outstanding_o), 64'd2);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_cnt", 64'(outstanding_o), 64'd0);
        next();
        rst_ni = 1'b1;
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        settle();
        chk("t6_stale_rvalid", 64'(rvalid_o), 64'd0);
        chk("t6_post_rst_cnt", 64'(outstanding_o), 64'd0);
        next();
        drive(2'b11, 2'b00, 1'b1, 1'b0, 1'b0);
        exp_gnt.push_back(0);
        settle();
        next();
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        push_rsp(0, 1'b0);
        settle();
        next();
        drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        repeat (2) next();

        chk("gnt_left", 64'(exp_gnt.size()), 64'd0);
        chk("rsp_left", 64'(exp_rsp.size()), 64'd0);
        chk("fix_gnt_left", 64'(fix_gnt.size()), 64'd0);
        chk("fix_rsp_left", 64'(fix_rsp.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
